// File: rtl/invol_arbiter_pkg.sv
// Shared definitions for the involuntary-message arbiter, the command dispatcher and the framer.
package invol_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT   = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_e;

   localparam int ARB_PW_DEFAULT      = 33;
   localparam int ARB_TIMEOUT_DEFAULT = 4096;

   // Index width for n requesters; a single requester still needs one bit.
   function automatic int owner_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/invol_arbiter_if.sv
// Bundle of requester-side and framer-side signals shared by the involuntary arbiter.
interface invol_arbiter_if
   import invol_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = ARB_PW_DEFAULT
) ();
   localparam int OW = owner_width(NREQ);

   logic                 cmd_busy;
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      grant;
   logic [NREQ*PW-1:0]   src_param_data;
   logic [NREQ-1:0]      src_param_write;
   logic [NREQ-1:0]      src_done;
   logic [PW-1:0]        out_param_data;
   logic                 out_param_write;
   logic                 out_done;
   logic                 out_abort;
   logic                 invol_active;
   logic                 timeout_err;
   logic [OW-1:0]        owner;

   modport master (
      input  cmd_busy, req, src_param_data, src_param_write, src_done,
      output grant, out_param_data, out_param_write, out_done, out_abort,
             invol_active, timeout_err, owner
   );

   modport slave (
      output cmd_busy, req, src_param_data, src_param_write, src_done,
      input  grant, out_param_data, out_param_write, out_done, out_abort,
             invol_active, timeout_err, owner
   );
endinterface

// File: rtl/invol_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module invol_arbiter_rr_pick
   import invol_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = owner_width(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] pick_o,
   output logic [IW-1:0]   idx_o,
   output logic            valid_o
);

   always_comb begin
      int unsigned c;
      pick_o  = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      c       = 0;
      for (int k = 0; k < NREQ; k++) begin
         c = (int'(ptr_i) + k) % NREQ;
         if (!valid_o && req_i[c]) begin
            valid_o   = 1'b1;
            idx_o     = IW'(c);
            pick_o[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/invol_arbiter.sv
// Round-robin arbiter sharing the response/param channel among involuntary message
// sources, yielding to the command dispatcher and reclaiming stuck grants via a watchdog.
//
// state       | meaning
// ARB_IDLE    | channel free; grant next cycle if cmd_busy=0 and any req
// ARB_GRANT   | owner's param stream muxed to framer; watchdog running
// ARB_RELEASE | one turnaround cycle before the channel is offered again
module invol_arbiter
   import invol_arbiter_pkg::*;
#(
   parameter int NREQ           = 4,
   parameter int PW             = ARB_PW_DEFAULT,
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
   parameter int TO_BITS        = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic               clk,
   input  logic               rst,
   invol_arbiter_if.master    bus
);
   localparam int OW = owner_width(NREQ);

   arb_state_e          state_q, state_d;
   logic [OW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [OW-1:0]       owner_q, owner_d;
   logic [NREQ-1:0]     grant_q, grant_d;
   logic [TO_BITS-1:0]  wd_q, wd_d;
   logic [PW-1:0]       data_q, data_d;
   logic                write_q, write_d;
   logic                done_q, done_d;
   logic                abort_q, abort_d;
   logic                err_q, err_d;

   logic [NREQ-1:0]     pick_oh;
   logic [OW-1:0]       pick_idx;
   logic                pick_valid;
   logic [OW-1:0]       owner_nxt;
   logic [PW-1:0]       own_data;
   logic                own_write;
   logic                own_done;
   logic                wd_expired;

   invol_arbiter_rr_pick #(.NREQ(NREQ), .IW(OW)) u_rr_pick (
      .req_i   (bus.req),
      .ptr_i   (rr_ptr_q),
      .pick_o  (pick_oh),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   always_comb begin
      owner_nxt  = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
      own_data   = bus.src_param_data[int'(owner_q)*PW +: PW];
      own_write  = bus.src_param_write[owner_q];
      own_done   = bus.src_done[owner_q];
      wd_expired = (wd_q == TO_BITS'(TIMEOUT_CYCLES - 1));
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      grant_d  = grant_q;
      wd_d     = wd_q;
      data_d   = '0;
      write_d  = 1'b0;
      done_d   = 1'b0;
      abort_d  = 1'b0;
      err_d    = err_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (!bus.cmd_busy && pick_valid) begin
               state_d = ARB_GRANT;
               owner_d = pick_idx;
               grant_d = pick_oh;
               wd_d    = '0;
            end
         end
         ARB_GRANT: begin
            data_d  = own_data;
            write_d = own_write;
            wd_d    = wd_q + TO_BITS'(1);
            // A done on the expiry cycle still counts as a clean completion.
            if (own_done) begin
               done_d   = 1'b1;
               grant_d  = '0;
               rr_ptr_d = owner_nxt;
               state_d  = ARB_RELEASE;
            end else if (wd_expired) begin
               data_d   = '0;
               write_d  = 1'b0;
               abort_d  = 1'b1;
               err_d    = 1'b1;
               grant_d  = '0;
               rr_ptr_d = owner_nxt;
               state_d  = ARB_RELEASE;
            end
         end
         ARB_RELEASE: state_d = ARB_IDLE;
         default:     state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         grant_q  <= '0;
         wd_q     <= '0;
         data_q   <= '0;
         write_q  <= 1'b0;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         grant_q  <= grant_d;
         wd_q     <= wd_d;
         data_q   <= data_d;
         write_q  <= write_d;
         done_q   <= done_d;
         abort_q  <= abort_d;
         err_q    <= err_d;
      end
   end

   assign bus.grant           = grant_q;
   assign bus.out_param_data  = data_q;
   assign bus.out_param_write = write_q;
   assign bus.out_done        = done_q;
   assign bus.out_abort       = abort_q;
   assign bus.invol_active    = (state_q != ARB_IDLE);
   assign bus.timeout_err     = err_q;
   assign bus.owner           = owner_q;

endmodule

// File: tb/tb_invol_arbiter.sv
// Directed bench for invol_arbiter: vector table for a single grant, hand sequences for
// round-robin, dispatcher priority, watchdog and mid-grant reset.
module tb_invol_arbiter;
   import invol_arbiter_pkg::*;

   localparam int NREQ = 4;
   localparam int PW   = 33;
   localparam int TO   = 16;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [PW-1:0] sd [NREQ];

   invol_arbiter_if #(.NREQ(NREQ), .PW(PW)) bus ();

   assign bus.src_param_data = {sd[3], sd[2], sd[1], sd[0]};

   invol_arbiter #(.NREQ(NREQ), .PW(PW), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic        busy;
      logic [3:0]  wr;
      logic [3:0]  done;
      logic [32:0] d2;
      logic [3:0]  e_grant;
      logic        e_wr;
      logic [32:0] e_data;
      logic        e_done;
      logic        e_active;
   } vec_t;

   vec_t vt [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_grant(output logic [3:0] g);
      g = bus.grant;
      for (int n = 0; n < 30 && g == 4'b0; n++) begin
         tick();
         g = bus.grant;
      end
      if (g == 4'b0) begin
         checks++;
         failures++;
         $display("FAIL wait_grant: got no grant within 30 cycles, expected a grant");
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"},  64'(bus.grant), 64'(0));
      chk({tag, "_write"},  64'(bus.out_param_write), 64'(0));
      chk({tag, "_data"},   64'(bus.out_param_data), 64'(0));
      chk({tag, "_done"},   64'(bus.out_done), 64'(0));
      chk({tag, "_abort"},  64'(bus.out_abort), 64'(0));
      chk({tag, "_active"}, 64'(bus.invol_active), 64'(0));
      chk({tag, "_err"},    64'(bus.timeout_err), 64'(0));
      chk({tag, "_owner"},  64'(bus.owner), 64'(0));
   endtask

   initial begin
      logic [3:0] g;
      logic [3:0] rr_exp [6];

      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.cmd_busy        = 1'b0;
      bus.req             = '0;
      bus.src_param_write = '0;
      bus.src_done        = '0;
      for (int i = 0; i < NREQ; i++) sd[i] = 33'h0_FFFF_FFFF;

      vt[0] = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 33'h0,           4'b0100, 1'b0, 33'h0,           1'b0, 1'b1};
      vt[1] = '{4'b0000, 1'b0, 4'b0100, 4'b0000, 33'h1_0000_0005, 4'b0100, 1'b1, 33'h1_0000_0005, 1'b0, 1'b1};
      vt[2] = '{4'b0000, 1'b0, 4'b1111, 4'b0000, 33'h0_DEAD_BEEF, 4'b0100, 1'b1, 33'h0_DEAD_BEEF, 1'b0, 1'b1};
      vt[3] = '{4'b0000, 1'b0, 4'b1011, 4'b1011, 33'h0,           4'b0100, 1'b0, 33'h0,           1'b0, 1'b1};
      vt[4] = '{4'b0000, 1'b0, 4'b0000, 4'b0100, 33'h0,           4'b0000, 1'b0, 33'h0,           1'b1, 1'b1};
      vt[5] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 33'h0,           4'b0000, 1'b0, 33'h0,           1'b0, 1'b0};

      // reset state
      tick();
      tick();
      rst = 1'b0;
      chk_all_zero("reset");

      // single request with non-owner isolation
      for (int i = 0; i < 6; i++) begin
         bus.req             = vt[i].req;
         bus.cmd_busy        = vt[i].busy;
         bus.src_param_write = vt[i].wr;
         bus.src_done        = vt[i].done;
         sd[2]               = vt[i].d2;
         tick();
         chk($sformatf("vec%0d_grant", i),  64'(bus.grant), 64'(vt[i].e_grant));
         chk($sformatf("vec%0d_write", i),  64'(bus.out_param_write), 64'(vt[i].e_wr));
         chk($sformatf("vec%0d_data", i),   64'(bus.out_param_data), 64'(vt[i].e_data));
         chk($sformatf("vec%0d_done", i),   64'(bus.out_done), 64'(vt[i].e_done));
         chk($sformatf("vec%0d_active", i), 64'(bus.invol_active), 64'(vt[i].e_active));
      end
      sd[2] = 33'h0_FFFF_FFFF;

      // round-robin contention
      do_reset();
      rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
      bus.req = 4'b1011;
      for (int i = 0; i < 6; i++) begin
         wait_grant(g);
         chk($sformatf("rr%0d_grant", i), 64'(g), 64'(rr_exp[i]));
         bus.src_done = g;
         tick();
         bus.src_done = '0;
         chk($sformatf("rr%0d_rel_grant", i), 64'(bus.grant), 64'(0));
         chk($sformatf("rr%0d_rel_active", i), 64'(bus.invol_active), 64'(1));
         chk($sformatf("rr%0d_done", i), 64'(bus.out_done), 64'(1));
         tick();
         chk($sformatf("rr%0d_idle_grant", i), 64'(bus.grant), 64'(0));
      end
      bus.req = '0;

      // dispatcher priority
      do_reset();
      bus.cmd_busy = 1'b1;
      bus.req      = 4'b0010;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("busy%0d_grant", i), 64'(bus.grant), 64'(0));
      end
      chk("busy_active", 64'(bus.invol_active), 64'(0));
      bus.cmd_busy = 1'b0;
      tick();
      chk("unbusy_grant", 64'(bus.grant), 64'(4'b0010));
      chk("unbusy_owner", 64'(bus.owner), 64'(1));
      bus.req      = '0;
      bus.src_done = 4'b0010;
      tick();
      bus.src_done = '0;
      chk("unbusy_done", 64'(bus.out_done), 64'(1));
      tick();
      // simultaneous cmd_busy and req rise
      bus.cmd_busy = 1'b1;
      bus.req      = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("same%0d_grant", i), 64'(bus.grant), 64'(0));
      end
      bus.cmd_busy = 1'b0;
      tick();
      chk("same_grant", 64'(bus.grant), 64'(4'b0001));
      bus.req = '0;

      // done on the last watchdog cycle completes normally
      for (int k = 2; k <= TO; k++) begin
         tick();
         chk($sformatf("edge_hold%0d", k), 64'(bus.grant), 64'(4'b0001));
      end
      bus.src_done = 4'b0001;
      tick();
      bus.src_done = '0;
      chk("edge_done",  64'(bus.out_done), 64'(1));
      chk("edge_abort", 64'(bus.out_abort), 64'(0));
      chk("edge_err",   64'(bus.timeout_err), 64'(0));
      chk("edge_grant", 64'(bus.grant), 64'(0));
      tick();

      // watchdog expiry: rr_ptr is now 1, so source 2 is picked
      bus.req = 4'b0100;
      wait_grant(g);
      chk("wd_grant", 64'(g), 64'(4'b0100));
      bus.req             = '0;
      bus.src_param_write = 4'b0100;
      sd[2]               = 33'h0_1234_5678;
      for (int k = 2; k <= TO; k++) begin
         tick();
         chk($sformatf("wd_hold%0d", k), 64'(bus.grant), 64'(4'b0100));
         chk($sformatf("wd_noabort%0d", k), 64'(bus.out_abort), 64'(0));
      end
      tick();
      chk("wd_grant_drop", 64'(bus.grant), 64'(0));
      chk("wd_abort",      64'(bus.out_abort), 64'(1));
      chk("wd_err",        64'(bus.timeout_err), 64'(1));
      chk("wd_write",      64'(bus.out_param_write), 64'(0));
      chk("wd_done",       64'(bus.out_done), 64'(0));
      chk("wd_active",     64'(bus.invol_active), 64'(1));
      bus.src_param_write = '0;
      sd[2]               = 33'h0_FFFF_FFFF;
      tick();
      chk("wd_abort_pulse", 64'(bus.out_abort), 64'(0));
      chk("wd_err_sticky",  64'(bus.timeout_err), 64'(1));
      chk("wd_idle",        64'(bus.invol_active), 64'(0));
      bus.req = 4'b1000;
      wait_grant(g);
      chk("wd_next_grant", 64'(g), 64'(4'b1000));
      chk("wd_err_hold",   64'(bus.timeout_err), 64'(1));
      bus.req      = '0;
      bus.src_done = 4'b1000;
      tick();
      bus.src_done = '0;
      tick();

      // reset mid-grant: move rr_ptr to 2, grant source 3, then reset during word 2
      bus.req = 4'b0010;
      wait_grant(g);
      chk("pre_rst_grant1", 64'(g), 64'(4'b0010));
      bus.req      = '0;
      bus.src_done = 4'b0010;
      tick();
      bus.src_done = '0;
      tick();
      bus.req = 4'b1001;
      wait_grant(g);
      chk("pre_rst_grant3", 64'(g), 64'(4'b1000));
      bus.src_param_write = 4'b1000;
      sd[3]               = 33'h0_AAAA_0001;
      tick();
      chk("pre_rst_word1", 64'(bus.out_param_data), 64'(33'h0_AAAA_0001));
      sd[3] = 33'h0_AAAA_0002;
      rst   = 1'b1;
      tick();
      chk_all_zero("rst_mid");
      rst                 = 1'b0;
      bus.src_param_write = '0;
      sd[3]               = 33'h0_FFFF_FFFF;
      tick();
      chk("post_rst_grant", 64'(bus.grant), 64'(4'b0001));
      chk("post_rst_owner", 64'(bus.owner), 64'(0));
      chk("post_rst_done",  64'(bus.out_done), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/invol_arbiter.md
Name: invol_arbiter

Overview:
- Shares the upstream response/parameter channel (param_data, param_write, cmd_done path into the response framer) between NREQ involuntary message sources: system shutdown report, endstop triggers, stepper faults, and similar.
- Grants one source at a time, round-robin, and never while the command dispatcher owns the channel.
- Muxes the granted source's param stream to the framer through one register stage.
- A watchdog reclaims the channel from a source that never finishes.

Parameters:
- NREQ, 4, number of involuntary requesters (1..16)
- PW, 33, width of param_data words
- TIMEOUT_CYCLES, 4096, maximum cycles a grant may be held before forced release
- TO_BITS, $clog2(TIMEOUT_CYCLES+1), watchdog counter width (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_busy  in  1  dispatcher is executing a command and owns the channel
- req  in  NREQ  per-source involuntary request (invol_req)
- grant  out  NREQ  one-hot grant (invol_grant)
- src_param_data  in  NREQ*PW  per-source param word; source i at [i*PW +: PW]
- src_param_write  in  NREQ  per-source param_write
- src_done  in  NREQ  per-source end-of-message pulse (cmd_done)
- out_param_data  out  PW  to framer
- out_param_write  out  1  to framer
- out_done  out  1  end-of-message pulse to framer
- out_abort  out  1  one-cycle pulse; framer discards the partial message
- invol_active  out  1  channel held by the arbiter; dispatcher must not accept a new command
- timeout_err  out  1  sticky; set on any watchdog expiry
- owner  out  $clog2(NREQ) or 1 bit  index of the current or last grantee

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; rr pointer 0; watchdog 0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If cmd_busy=0 and |req, select the first set req[i] scanning from rr_ptr upward with wrap.
  - Next cycle: grant[i]=1, invol_active=1, owner=i, state GRANT, watchdog cleared.
  - cmd_busy=1 blocks all grants; cmd_busy and req rising in the same cycle → dispatcher wins.
  - Request-to-grant latency: 1 cycle.
- GRANT:
  - grant stays asserted until src_done[owner]. A requester dropping req (normal on grant) does not end the grant.
  - Registered mux, 1 cycle latency: out_param_data/out_param_write/out_done ← source owner's values. Word order and count are preserved exactly.
  - Non-owner src_* inputs are ignored entirely.
  - On src_done[owner]:
    - out_done pulses next cycle.
    - grant drops next cycle.
    - rr_ptr ← owner+1, mod NREQ.
    - state RELEASE.
  - Watchdog increments each GRANT cycle. On reaching TIMEOUT_CYCLES without done:
    - grant drops.
    - out_param_write forced 0.
    - out_abort pulses one cycle.
    - timeout_err ← 1.
    - rr_ptr ← owner+1.
    - state RELEASE.
  - src_done on the same cycle the watchdog expires: treat as a normal completion (out_done, no abort, no err).
- RELEASE:
  - One turnaround cycle; outputs 0 except invol_active, which stays 1.
  - Next cycle → IDLE, invol_active=0.
  - Back-to-back grants are therefore separated by ≥2 idle cycles on out_param_write.
- invol_active = (state != IDLE).
- Outside GRANT (plus the one trailing mux cycle), out_param_data=0 and out_param_write=0.
- rst mid-grant: immediate return to reset values. No out_done or out_abort is emitted. The framer is reset by the same rst.
- NREQ=1: rr logic degenerates; owner is 0.

Decomposition:
- Shared package, for use by the dispatcher and framer as well:
  - state encodings (ARB_IDLE/ARB_GRANT/ARB_RELEASE)
  - PW default
  - default TIMEOUT_CYCLES
- One sub-module: rr_pick, combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot pick, index, valid.
  - Reused by any future arbiter in the design.

Test Plan:
- Single request: req[2]=1 at t0, cmd_busy=0 → grant[2] at t0+1. Source writes 3 words (0x1_0000_0005, 0x0_DEAD_BEEF, done) → identical words on out_param_* one cycle later; out_done once; invol_active high through RELEASE.
- Contention round-robin (NREQ=4): req=4'b1011 held continuously after each done → grant order 0,1,3,0,1,3; every done followed by ≥1 RELEASE cycle.
- Dispatcher priority: cmd_busy=1 while req[1]=1 for 10 cycles → no grant. cmd_busy falls at t → grant[1] at t+1. Same-cycle cmd_busy and req rise → no grant until cmd_busy clears.
- Watchdog (TIMEOUT_CYCLES=16): granted source never asserts done → after 16 GRANT cycles: out_abort pulses, grant drops, timeout_err=1 and stays 1. Next requester is then granted normally.
- Isolation: non-owner sources drive src_param_write=1 with 0xFFFFFFFF during a grant → out_param_data carries only the owner's words.
- Reset mid-grant: rst asserted during the 2nd word → next cycle all outputs 0, no out_done. After rst release, req[0] is granted first (rr_ptr=0).
